// File: rtl/lock_arbiter.sv
// ---------------------------------------------------------------------------------------------
// lock_arbiter
//
// Lock-style arbiter for a shared resource. A requester raises its req bit and keeps it high for
// as long as it needs the resource. Once granted, it keeps the grant until it drops req.
// After every release the grant is all-zero for at least one cycle. The search pointer then moves
// just past the released owner, so the previous owner has the lowest priority at the next
// arbitration.
//
// Optional feature, enabled by defining the macro LOCK_ARB_TIMEOUT_EN:
//   A grant that has lasted MAX_HOLD cycles is revoked. timeout pulses for one cycle, and the
//   former owner is masked until it drops and re-raises its request. With the macro undefined,
//   grants are unlimited, timeout is tied low and no requester is ever masked.
//
// Parameters
//   REQS      number of requesters (2..16)
//   MAX_HOLD  longest grant, in cycles, when the timeout feature is built in (2..256)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request level
//   grant      registered one-hot grant, or all-zero
//   grant_vld  high exactly when grant is non-zero
//   grant_id   binary index of the granted requester; zero when grant_vld is low
//   timeout    one-cycle pulse marking a forced release
// ---------------------------------------------------------------------------------------------
module lock_arbiter #(
  parameter int unsigned  REQS     = 4,
  parameter int unsigned  MAX_HOLD = 16,
  localparam int unsigned IdW      = $clog2(REQS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REQS-1:0] req,
  output logic [REQS-1:0] grant,
  output logic            grant_vld,
  output logic [IdW-1:0]  grant_id,
  output logic            timeout
);

  localparam int unsigned      HoldW   = $clog2(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);
  localparam logic [IdW-1:0]   LastId  = IdW'(REQS - 1);
  localparam logic [REQS-1:0]  OneHot0 = REQS'(1);

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  state_e           state_q,     state_d;
  logic [REQS-1:0]  grant_q,     grant_d;
  logic             grant_vld_q, grant_vld_d;
  logic [IdW-1:0]   owner_q,     owner_d;
  logic [IdW-1:0]   ptr_q,       ptr_d;
  logic [HoldW-1:0] hold_q,      hold_d;
  logic [REQS-1:0]  mask_q,      mask_d;
  logic             timeout_q,   timeout_d;

  // -------------------------------------------------------------------------------------------
  // Rotating search: the first unmasked request at or above ptr_q, wrapping past REQS-1 to 0.
  // -------------------------------------------------------------------------------------------
  logic [REQS-1:0] cand;
  logic            pick_vld;
  logic [IdW-1:0]  pick_id;
  int unsigned     idx;
  logic [IdW-1:0]  sel;

  always_comb begin
    cand     = req & ~mask_q;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    sel      = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= REQS) begin
        idx = idx - REQS;
      end
      sel = IdW'(idx);
      if (!pick_vld && cand[sel]) begin
        pick_vld = 1'b1;
        pick_id  = sel;
      end
    end
  end

  // Pointer value after a release: one past the current owner, modulo REQS.
  logic [IdW-1:0] ptr_after_owner;

  always_comb begin
    if (owner_q == LastId) begin
      ptr_after_owner = '0;
    end else begin
      ptr_after_owner = owner_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_vld_d = grant_vld_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`ifdef LOCK_ARB_TIMEOUT_EN
    // A mask bit lasts only until its requester is seen with req low.
    mask_d      = mask_q & req;
`else
    mask_d      = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d     = StOwn;
          grant_d     = OneHot0 << pick_id;
          grant_vld_d = 1'b1;
          owner_d     = pick_id;
          hold_d      = '0;
        end
      end

      StOwn: begin
        if (!req[owner_q]) begin
          state_d     = StIdle;
          grant_d     = '0;
          grant_vld_d = 1'b0;
          owner_d     = '0;
          ptr_d       = ptr_after_owner;
        end
`ifdef LOCK_ARB_TIMEOUT_EN
        else if (hold_q == HoldMax) begin
          // Forced release; the owner must drop req before it can win again.
          state_d         = StIdle;
          grant_d         = '0;
          grant_vld_d     = 1'b0;
          owner_d         = '0;
          ptr_d           = ptr_after_owner;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end
`endif
        else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        grant_d     = '0;
        grant_vld_d = 1'b0;
        owner_d     = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      mask_q      <= mask_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign grant_id  = owner_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_lock_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_lock_arbiter
//
// Self-checking bench for lock_arbiter with REQS=4 and MAX_HOLD=8. A behavioural model tracks
// the owner, the search start, the number of cycles the grant has been visible, and the masked
// requesters. Outputs are sampled 1 time unit after each rising edge. The timeout expectations
// follow LOCK_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------------------------
module tb_lock_arbiter;

  localparam int unsigned REQS     = 4;
  localparam int unsigned MAX_HOLD = 8;
`ifdef LOCK_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_vld;
  logic [1:0] grant_id;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Model state: owner (-1 = none), search start, cycles the grant has been visible, masks.
  int m_owner;
  int m_ptr;
  int m_gc;
  bit m_mask [4];
  bit m_to;

  lock_arbiter #(
    .REQS     (REQS),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gc    = 0;
    m_to    = 1'b0;
    for (int k = 0; k < 4; k++) m_mask[k] = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (m_owner < 0 && r[k] && !m_mask[k]) begin
          m_owner = k;
          m_gc    = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (TimeoutEn && m_gc == MAX_HOLD) begin
      m_mask[m_owner] = 1'b1;
      m_to            = 1'b1;
      m_ptr           = (m_owner + 1) % 4;
      m_owner         = -1;
    end else begin
      m_gc++;
    end
    for (int k = 0; k < 4; k++) begin
      if (!r[k]) m_mask[k] = 1'b0;
    end
  endtask

  function automatic logic [3:0] exp_grant();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
  endfunction

  // Drive req, advance one rising edge, update the model, then settle before sampling.
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    #1;
    checks++;
    if ({grant, grant_vld, grant_id, timeout} !== 8'b0) begin
      failures++;
      $display("FAIL reset_async got=%b want=00000000", {grant, grant_vld, grant_id, timeout});
    end
    for (int n = 0; n < 2; n++) begin
      cycle(4'b1111);
      checks++;
      if ({grant, grant_vld, grant_id, timeout} !== 8'b0) begin
        failures++;
        $display("FAIL reset_hold got=%b want=00000000", {grant, grant_vld, grant_id, timeout});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(4'b0001);
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_first got=%b/%0d want=0001/0", grant, grant_id);
    end
  endtask

  task automatic test_basic();
    logic [3:0] t_req [5];
    logic [3:0] t_gnt [5];
    logic [1:0] t_id  [5];
    t_req = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0000};
    t_gnt = '{4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    t_id  = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      cycle(t_req[n]);
      checks++;
      if (grant !== t_gnt[n] || grant_id !== t_id[n] || grant_vld !== (t_gnt[n] != 0)) begin
        failures++;
        $display("FAIL basic[%0d] got=%b/%0d/%b want=%b/%0d", n, grant, grant_id, grant_vld,
                 t_gnt[n], t_id[n]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want [5];
    logic [3:0] prev;
    logic [3:0] r;
    int         seen;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seen = 0;
    prev = 4'b0000;
    do_reset();
    for (int n = 0; n < 40 && seen < 5; n++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_gc == 2) r[m_owner] = 1'b0;
      cycle(r);
      checks++;
      if ({grant, grant_vld, grant_id, timeout} !== {exp_grant(), m_owner >= 0, exp_id(), m_to})
      begin
        failures++;
        $display("FAIL rotation_model cyc=%0d got=%b want=%b", n,
                 {grant, grant_vld, grant_id, timeout},
                 {exp_grant(), m_owner >= 0, exp_id(), m_to});
      end
      if (grant !== 4'b0000 && grant !== prev) begin
        checks++;
        if (grant !== want[seen] || prev !== 4'b0000) begin
          failures++;
          $display("FAIL rotation_seq[%0d] got=%b prev=%b want=%b prev=0000", seen, grant, prev,
                   want[seen]);
        end
        seen++;
      end
      prev = grant;
    end
    checks++;
    if (seen != 5) begin
      failures++;
      $display("FAIL rotation_count got=%0d want=5", seen);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] t_req [4];
    t_req = '{4'b1000, 4'b1001, 4'b0001, 4'b1001};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      cycle(t_req[n]);
      checks++;
      if ({grant, grant_vld, grant_id, timeout} !== {exp_grant(), m_owner >= 0, exp_id(), m_to})
      begin
        failures++;
        $display("FAIL wrap_model[%0d] got=%b want=%b", n, {grant, grant_vld, grant_id, timeout},
                 {exp_grant(), m_owner >= 0, exp_id(), m_to});
      end
    end
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL wrap_grant got=%b/%0d want=0001/0", grant, grant_id);
    end
  endtask

  task automatic test_timeout();
    int g_cnt;
    int t_cnt;
    g_cnt = 0;
    t_cnt = 0;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cycle(4'b0100);
      if (grant === 4'b0100) g_cnt++;
      if (timeout === 1'b1) begin
        t_cnt++;
        checks++;
        if (grant !== 4'b0000) begin
          failures++;
          $display("FAIL timeout_grant got=%b want=0000", grant);
        end
      end
      checks++;
      if ({grant, grant_vld, grant_id, timeout} !== {exp_grant(), m_owner >= 0, exp_id(), m_to})
      begin
        failures++;
        $display("FAIL timeout_model cyc=%0d got=%b want=%b", n,
                 {grant, grant_vld, grant_id, timeout},
                 {exp_grant(), m_owner >= 0, exp_id(), m_to});
      end
    end
    checks++;
    if (g_cnt != (TimeoutEn ? 8 : 20) || t_cnt != (TimeoutEn ? 1 : 0)) begin
      failures++;
      $display("FAIL timeout_len got=%0d/%0d want=%0d/%0d", g_cnt, t_cnt, TimeoutEn ? 8 : 20,
               TimeoutEn ? 1 : 0);
    end
    cycle(4'b0000);
    cycle(4'b0100);
    checks++;
    if (grant !== 4'b0100 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant got=%b/%b want=0100/0", grant, timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(4'b0010);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL areset_pre got=%b want=0010", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({grant, grant_vld, grant_id, timeout} !== 8'b0) begin
      failures++;
      $display("FAIL areset_drop got=%b want=00000000", {grant, grant_vld, grant_id, timeout});
    end
    #1;
    rst = 1'b0;
    model_reset();
    cycle(4'b1010);
    checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL areset_restart got=%b/%0d want=0010/1", grant, grant_id);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(3) == 0) r[k] = ~r[k];
      end
      cycle(r);
      checks++;
      if ({grant, grant_vld, grant_id, timeout} !== {exp_grant(), m_owner >= 0, exp_id(), m_to})
      begin
        failures++;
        $display("FAIL random cyc=%0d req=%b got=%b want=%b", n, r,
                 {grant, grant_vld, grant_id, timeout},
                 {exp_grant(), m_owner >= 0, exp_id(), m_to});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    test_reset();
    test_basic();
    test_rotation();
    test_wrap();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
